// File: rtl/ecg_window_feeder.sv
// Frames a valid/ready ECG sample stream into NSAMP-sample windows for the
// arrhythmia core, sequences the core's reset and tracks completion/timeout.
module ecg_window_feeder #(
  parameter int BITSIZE = 16,
  parameter int NSAMP   = 10,
  parameter int HOP     = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BITSIZE-1:0]         s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [BITSIZE*NSAMP-1:0]   x,
  output logic                       core_reset,
  input  logic                       core_done,
  output logic                       win_done,
  output logic [15:0]                win_count,
  output logic                       timeout
);

  localparam int CW = $clog2(NSAMP + 1);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              fill_cnt_q, fill_cnt_d, thresh;
  logic [WW-1:0]              wait_cnt_q, wait_cnt_d;
  logic                       primed_q, primed_d;
  logic [BITSIZE*NSAMP-1:0]   x_q, x_d;
  logic                       s_ready_q, s_ready_d;
  logic                       core_reset_q, core_reset_d;
  logic                       win_done_q, win_done_d;
  logic [15:0]                win_count_q, win_count_d;
  logic                       timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      fill_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      primed_q     <= 1'b0;
      x_q          <= '0;
      s_ready_q    <= 1'b0;
      core_reset_q <= 1'b1;
      win_done_q   <= 1'b0;
      win_count_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      primed_q     <= primed_d;
      x_q          <= x_d;
      s_ready_q    <= s_ready_d;
      core_reset_q <= core_reset_d;
      win_done_q   <= win_done_d;
      win_count_q  <= win_count_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    primed_d     = primed_q;
    x_d          = x_q;
    s_ready_d    = s_ready_q;
    core_reset_d = core_reset_q;
    win_done_d   = 1'b0;
    win_count_d  = win_count_q;
    timeout_d    = timeout_q;
    // After the first window only HOP fresh samples are needed.
    thresh       = primed_q ? CW'(HOP) : CW'(NSAMP);

    case (state_q)
      S_FILL: begin
        s_ready_d    = 1'b1;
        core_reset_d = 1'b1;
        if (s_valid && s_ready_q) begin
          x_d = {x_q[BITSIZE*(NSAMP-1)-1:0], s_data};
          if (fill_cnt_q + CW'(1) == thresh) begin
            state_d    = S_LAUNCH;
            primed_d   = 1'b1;
            fill_cnt_d = '0;
            s_ready_d  = 1'b0;
          end else begin
            fill_cnt_d = fill_cnt_q + CW'(1);
          end
        end
      end
      S_LAUNCH: begin
        // Core stays in reset this cycle while x is already final.
        state_d      = S_WAIT;
        wait_cnt_d   = '0;
        core_reset_d = 1'b0;
        s_ready_d    = 1'b0;
      end
      S_WAIT: begin
        if (core_done) begin
          win_done_d   = 1'b1;
          win_count_d  = win_count_q + 16'd1;
          state_d      = S_FILL;
          core_reset_d = 1'b1;
          s_ready_d    = 1'b1;
        end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
          timeout_d    = 1'b1;
          state_d      = S_FILL;
          core_reset_d = 1'b1;
          s_ready_d    = 1'b1;
        end else begin
          wait_cnt_d   = wait_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  assign s_ready    = s_ready_q;
  assign x          = x_q;
  assign core_reset = core_reset_q;
  assign win_done   = win_done_q;
  assign win_count  = win_count_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ecg_window_feeder.sv
// Random-stimulus bench for ecg_window_feeder: a sample-history reference model
// feeds expected windows/completions into queues checked by a separate monitor.
module tb_ecg_window_feeder;
  localparam int BITSIZE = 16;
  localparam int NSAMP   = 10;
  localparam int HOP     = 5;
  localparam int TIMEOUT = 64;
  localparam int W       = BITSIZE * NSAMP;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [BITSIZE-1:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic [W-1:0]       x;
  logic               core_reset;
  logic               core_done;
  logic               win_done;
  logic [15:0]        win_count;
  logic               timeout;

  ecg_window_feeder #(.BITSIZE(BITSIZE), .NSAMP(NSAMP), .HOP(HOP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x(x), .core_reset(core_reset), .core_done(core_done), .win_done(win_done),
    .win_count(win_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit no_done = 0;
  bit stop_drv = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Reference model state: expected outputs after the latest edge.
  logic [BITSIZE-1:0] hist[$];
  logic [BITSIZE-1:0] xq[$];
  logic [W-1:0]       exp_win_q[$];
  logic [15:0]        exp_done_q[$];
  logic [W-1:0]       e_x = '0;
  logic               e_sready = 1'b0, e_creset = 1'b1, e_wdone = 1'b0, e_timeout = 1'b0;
  logic [15:0]        e_wcount = '0;
  int                 fcnt = 0, wfirst = 0;
  bit                 primed = 0, busy = 0;

  initial begin
    for (int i = 0; i < NSAMP; i++) xq.push_back('0);
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        hist.delete(); xq.delete();
        for (int i = 0; i < NSAMP; i++) xq.push_back('0);
        exp_win_q.delete(); exp_done_q.delete();
        fcnt = 0; primed = 0; busy = 0;
        e_sready = 0; e_creset = 1; e_wdone = 0; e_wcount = 0; e_timeout = 0;
      end else begin
        e_wdone = 0;
        if (busy) begin
          if (cyc >= wfirst) begin
            if (core_done) begin
              e_wdone = 1; e_wcount = e_wcount + 16'd1; busy = 0;
              exp_done_q.push_back(e_wcount);
            end else if (cyc == wfirst + TIMEOUT - 1) begin
              e_timeout = 1; busy = 0;
            end
          end
        end else if (s_valid && s_ready) begin
          hist.push_back(s_data);
          void'(xq.pop_front());
          xq.push_back(s_data);
          fcnt++;
          if (fcnt == (primed ? HOP : NSAMP)) begin
            logic [W-1:0] w;
            for (int i = 0; i < NSAMP; i++)
              w[BITSIZE*(NSAMP-i)-1 -: BITSIZE] = hist[hist.size() - NSAMP + i];
            exp_win_q.push_back(w);
            fcnt = 0; primed = 1; busy = 1; wfirst = cyc + 2;
          end
        end
        e_sready = !busy;
        e_creset = !(busy && cyc >= wfirst - 1);
      end
      for (int i = 0; i < NSAMP; i++) e_x[BITSIZE*(NSAMP-i)-1 -: BITSIZE] = xq[i];
    end
  end

  // Source: holds each sample until it is accepted.
  initial begin
    bit took;
    s_valid = 0; s_data = '0;
    forever begin
      @(posedge clk);
      took = s_valid && s_ready && !reset;
      @(negedge clk);
      if (!s_valid || took) begin
        s_valid = !stop_drv && ($urandom_range(0, 3) != 0);
        s_data  = ($urandom_range(0, 7) == 0) ? 16'h1234 : 16'($urandom);
      end
    end
  end

  // Core model: random noise on done while held in reset, done after a random latency in WAIT.
  initial begin
    int wc, lat;
    wc = 0; lat = 0; core_done = 0;
    forever begin
      @(negedge clk);
      if (core_reset) begin
        wc = 0;
        core_done = 1'($urandom_range(0, 1));
      end else begin
        if (wc == 0) lat = no_done ? 100000 : int'($urandom_range(0, 8));
        core_done = (wc == lat);
        wc++;
      end
    end
  end

  // Monitor
  initial begin
    logic prev_cr;
    prev_cr = 1'b1;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("x", x, e_x);
        chk("s_ready", W'(s_ready), W'(e_sready));
        chk("core_reset", W'(core_reset), W'(e_creset));
        chk("win_done", W'(win_done), W'(e_wdone));
        chk("win_count", W'(win_count), W'(e_wcount));
        chk("timeout", W'(timeout), W'(e_timeout));
        if (prev_cr && !core_reset) begin
          if (exp_win_q.size() == 0) begin
            n_chk++;
            $display("FAIL launch_window @cyc %0d: got launch %h expected no launch", cyc, x);
          end else chk("launch_window", x, exp_win_q.pop_front());
        end
        if (win_done) begin
          if (exp_done_q.size() == 0) begin
            n_chk++;
            $display("FAIL win_done_event @cyc %0d: got pulse expected none", cyc);
          end else chk("done_count", W'(win_count), W'(exp_done_q.pop_front()));
        end
        prev_cr = core_reset;
      end
    end
  end

  initial begin
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (1500) @(negedge clk);

    no_done = 1;
    for (int i = 0; i < 1500 && !timeout; i++) @(negedge clk);
    chk("timeout_reached", W'(timeout), W'(1'b1));
    no_done = 0;
    repeat (400) @(negedge clk);

    for (int i = 0; i < 300 && core_reset; i++) @(negedge clk);
    chk("in_wait_before_reset", W'(core_reset), W'(1'b0));
    reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (600) @(negedge clk);

    stop_drv = 1;
    repeat (120) @(negedge clk);
    chk("win_q_drained", W'(exp_win_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
